// File: rtl/axis_drr_pkg.sv
// axis_drr_pkg: shared FSM states, width helpers and saturating deficit arithmetic for the DRR scheduler
package axis_drr_pkg;
    typedef enum logic [1:0] {SELECT, SEND, CHECK} drr_state_e;

    function automatic int def_w(input int qw);
        return qw + 2;
    endfunction

    function automatic int keep_cnt_w(input int dw);
        return $clog2(dw / 8) + 1;
    endfunction

    localparam int DEF_W = def_w(16);
    localparam int KEEP_CNT_W = keep_cnt_w(512);

    // Clamp to the signed range of a w-bit deficit register
    function automatic longint sat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input int w);
        return sat(a + b, w);
    endfunction

    function automatic longint sat_sub(input longint a, input longint b, input int w);
        return sat(a - b, w);
    endfunction
endpackage

// File: rtl/axis_keep_popcount.sv
// axis_keep_popcount: combinational count of asserted tkeep bits
module axis_keep_popcount #(
    parameter int KEEP_W = 64,
    parameter int CNT_W  = 7
) (
    input  logic [KEEP_W-1:0] keep_i,
    output logic [CNT_W-1:0]  cnt_o
);
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < KEEP_W; i++) cnt_o = cnt_o + CNT_W'(keep_i[i]);
    end
endmodule

// File: rtl/axis_drr_scheduler.sv
// axis_drr_scheduler: packet-granular deficit-round-robin mux of NUM_QUEUES AXI4-Stream queues
module axis_drr_scheduler
    import axis_drr_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES         = 4,
    parameter int QUANTUM_WIDTH      = 16
) (
    input  logic                                       axis_aclk,
    input  logic                                       axis_resetn,
    input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_QUEUES-1:0]                      s_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                      s_axis_tlast,
    output logic [NUM_QUEUES-1:0]                      s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]             m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]              m_axis_tuser,
    output logic                                       m_axis_tvalid,
    output logic                                       m_axis_tlast,
    input  logic                                       m_axis_tready,
    input  logic [NUM_QUEUES*QUANTUM_WIDTH-1:0]        quantum,
    output logic [$clog2(NUM_QUEUES)-1:0]              grant_q,
    output logic [NUM_QUEUES-1:0]                      pkt_sent
);
    localparam int KW       = C_AXIS_DATA_WIDTH / 8;
    localparam int PW       = $clog2(NUM_QUEUES);
    localparam int DEF_BITS = def_w(QUANTUM_WIDTH);
    localparam int CNT_BITS = keep_cnt_w(C_AXIS_DATA_WIDTH);

    drr_state_e                  state_q, state_d;
    logic [PW-1:0]               p_q, p_d, p_nxt;
    logic signed [DEF_BITS-1:0]  def_q [NUM_QUEUES];
    logic signed [DEF_BITS-1:0]  def_d [NUM_QUEUES];
    logic signed [DEF_BITS-1:0]  def_add, def_sub;
    logic [QUANTUM_WIDTH-1:0]    quant_p;
    logic [CNT_BITS-1:0]         keep_cnt;
    logic                        send, beat;

    assign quant_p       = quantum[int'(p_q)*QUANTUM_WIDTH +: QUANTUM_WIDTH];
    assign p_nxt         = (p_q == PW'(NUM_QUEUES - 1)) ? '0 : p_q + 1'b1;
    assign send          = state_q == SEND;
    assign m_axis_tdata  = s_axis_tdata[int'(p_q)*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
    assign m_axis_tkeep  = s_axis_tkeep[int'(p_q)*KW +: KW];
    assign m_axis_tuser  = s_axis_tuser[int'(p_q)*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
    assign m_axis_tlast  = s_axis_tlast[p_q];
    assign m_axis_tvalid = send & s_axis_tvalid[p_q];
    assign beat          = m_axis_tvalid & m_axis_tready;
    assign grant_q       = p_q;
    assign def_add = DEF_BITS'(sat_add(longint'(def_q[p_q]), longint'(quant_p), DEF_BITS));
    assign def_sub = DEF_BITS'(sat_sub(longint'(def_q[p_q]), longint'(keep_cnt), DEF_BITS));

    axis_keep_popcount #(.KEEP_W(KW), .CNT_W(CNT_BITS)) u_popcount (
        .keep_i (m_axis_tkeep),
        .cnt_o  (keep_cnt)
    );

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q <= SELECT;
            p_q     <= '0;
            def_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            def_q   <= def_d;
        end
    end

    // A queue whose deficit stays <= 0 after the quantum is added is skipped but keeps its debt
    always_comb begin
        state_d            = state_q;
        p_d                = p_q;
        def_d              = def_q;
        pkt_sent           = '0;
        s_axis_tready      = '0;
        s_axis_tready[p_q] = send & m_axis_tready;
        case (state_q)
            SELECT: begin
                if (s_axis_tvalid[p_q] && quant_p != '0) begin
                    def_d[p_q] = def_add;
                    if (def_add > 0) state_d = SEND;
                    else p_d = p_nxt;
                end else begin
                    def_d[p_q] = '0;
                    p_d        = p_nxt;
                end
            end
            SEND: begin
                if (beat) begin
                    def_d[p_q] = def_sub;
                    if (s_axis_tlast[p_q]) begin
                        pkt_sent[p_q] = 1'b1;
                        state_d       = CHECK;
                    end
                end
            end
            CHECK: begin
                if (s_axis_tvalid[p_q] && def_q[p_q] > 0) begin
                    state_d = SEND;
                end else begin
                    if (!s_axis_tvalid[p_q]) def_d[p_q] = '0;
                    p_d     = p_nxt;
                    state_d = SELECT;
                end
            end
            default: state_d = SELECT;
        endcase
    end
endmodule

// File: tb/tb_axis_drr_scheduler.sv
// tb_axis_drr_scheduler: directed self-checking bench for the DRR scheduler
module tb_axis_drr_scheduler;
    localparam int DW = 32, KW = 4, TUW = 8, NQ = 4, QW = 16;

    logic                clk = 1'b0, rst_n = 1'b0;
    logic [NQ*DW-1:0]    s_tdata;
    logic [NQ*KW-1:0]    s_tkeep;
    logic [NQ*TUW-1:0]   s_tuser;
    logic [NQ-1:0]       s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]       m_tdata;
    logic [KW-1:0]       m_tkeep;
    logic [TUW-1:0]      m_tuser;
    logic                m_tvalid, m_tlast, m_tready;
    logic [NQ*QW-1:0]    quantum;
    logic [1:0]          grant_q;
    logic [NQ-1:0]       pkt_sent;

    int vectors = 0, miscompares = 0;
    int rem[NQ], npk[NQ], psz[NQ], seq[NQ], pcnt[NQ], exp_seq[NQ];
    int order[$];
    int out_pkts, src_pkts, g;
    bit bp_mode, q3_rdy, prev_stall;
    logic [DW-1:0] prev_data;
    logic [KW-1:0] prev_keep;
    logic          prev_last;

    axis_drr_scheduler #(
        .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TUW), .NUM_QUEUES(NQ), .QUANTUM_WIDTH(QW)
    ) dut (
        .axis_aclk(clk), .axis_resetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .quantum(quantum), .grant_q(grant_q), .pkt_sent(pkt_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int q = 0; q < NQ; q++) begin
            int b;
            if (rem[q] == 0 && npk[q] > 0) begin
                rem[q] = psz[q];
                npk[q]--;
            end
            b = rem[q] >= KW ? KW : rem[q];
            s_tvalid[q]             = rem[q] != 0;
            s_tlast[q]              = rem[q] <= KW;
            s_tkeep[q*KW +: KW]     = KW'((1 << b) - 1);
            s_tdata[q*DW +: DW]     = {8'(q), 24'(seq[q])};
            s_tuser[q*TUW +: TUW]   = 8'(seq[q] + q);
        end
    endtask

    task automatic reset_src();
        for (int q = 0; q < NQ; q++) begin
            rem[q] = 0; npk[q] = 0; psz[q] = 0; seq[q] = 0; pcnt[q] = 0; exp_seq[q] = 0;
        end
        order.delete();
        out_pkts = 0; src_pkts = 0; prev_stall = 0; q3_rdy = 0; bp_mode = 0;
        m_tready = 1'b1;
        quantum  = '0;
    endtask

    // Sample settled outputs, advance one clock, then drive the next inputs
    task automatic tick();
        logic [NQ-1:0] hs;
        int q;
        hs = s_tvalid & s_tready;
        for (int i = 0; i < NQ; i++) if (hs[i] && s_tlast[i]) src_pkts++;
        if (prev_stall) begin
            chk("stable_valid", 64'(m_tvalid), 1);
            chk("stable_data", 64'(m_tdata), 64'(prev_data));
            chk("stable_keep", 64'(m_tkeep), 64'(prev_keep));
            chk("stable_last", 64'(m_tlast), 64'(prev_last));
        end
        if (m_tvalid && m_tready) begin
            q = int'(m_tdata[25:24]);
            chk("beat_seq", 64'(m_tdata[23:0]), 64'(exp_seq[q]));
            exp_seq[q]++;
            if (m_tlast) begin
                order.push_back(q);
                out_pkts++;
            end
        end
        for (int i = 0; i < NQ; i++) if (pkt_sent[i]) pcnt[i]++;
        if (s_tready[3]) q3_rdy = 1;
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_keep  = m_tkeep;
        prev_last  = m_tlast;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NQ; i++) if (hs[i]) begin
            rem[i] -= (rem[i] >= KW ? KW : rem[i]);
            seq[i]++;
        end
        m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        drive();
        #1;
    endtask

    task automatic start();
        @(negedge clk);
        rst_n = 1'b0;
        reset_src();
        drive();
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        drive();
        #1;
    endtask

    task automatic run_until(input int n, input int budget);
        int c = 0;
        while (out_pkts < n && c < budget) begin
            tick();
            c++;
        end
        chk("pkts_timeout", 64'(out_pkts >= n), 1);
    endtask

    task automatic gap(output int n);
        n = 0;
        while (!m_tvalid && n < 500) begin
            n++;
            tick();
        end
    endtask

    initial begin
        reset_src();
        drive();
        // Reset state
        start();
        chk("rst_tvalid", 64'(m_tvalid), 0);
        chk("rst_tready", 64'(s_tready), 0);
        chk("rst_grant", 64'(grant_q), 0);
        chk("rst_pkt_sent", 64'(pkt_sent), 0);
        // Idle pointer walk
        release_rst();
        chk("idle_grant", 64'(grant_q), 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("idle_grant", 64'(grant_q), 64'(i % 4));
            chk("idle_tvalid", 64'(m_tvalid), 0);
        end
        // Equal share: 58-byte packets, quantum 58
        start();
        quantum = {4{16'd58}};
        for (int q = 0; q < NQ; q++) begin psz[q] = 58; npk[q] = 1000; end
        release_rst();
        chk("lat_select", 64'(m_tvalid), 0);
        tick();
        chk("lat_send", 64'(m_tvalid), 1);
        chk("lat_grant", 64'(grant_q), 0);
        run_until(40, 2000);
        for (int i = 0; i < 12; i++) chk("equal_order", 64'(order[i]), 64'(i % 4));
        for (int q = 0; q < NQ; q++) chk("equal_cnt", 64'(pcnt[q] >= 9 && pcnt[q] <= 11), 1);
        // Weighted share: 116/58/58/0
        start();
        quantum = {16'd0, 16'd58, 16'd58, 16'd116};
        for (int q = 0; q < NQ; q++) begin psz[q] = 58; npk[q] = 1000; end
        release_rst();
        run_until(12, 2000);
        for (int i = 0; i < 12; i++) chk("weighted_order", 64'(order[i]), 64'((i % 4) < 2 ? 0 : (i % 4) - 1));
        chk("q3_never_ready", 64'(q3_rdy), 0);
        chk("q3_pkts", 64'(pcnt[3]), 0);
        // Debt carry: quantum 10, 100-byte packets -> 9 skipped visits of 4 cycles each
        start();
        quantum = {16'd58, 16'd58, 16'd58, 16'd10};
        psz[0] = 100; npk[0] = 1000;
        release_rst();
        run_until(1, 500);
        gap(g);
        chk("debt_gap1", 64'(g), 41);
        run_until(2, 500);
        gap(g);
        chk("debt_gap2", 64'(g), 41);
        // Empty queue clears leftover deficit in CHECK
        start();
        quantum = {4{16'd60}};
        psz[1] = 10; npk[1] = 1;
        release_rst();
        run_until(1, 200);
        chk("empty_q", 64'(order[0]), 1);
        psz[1] = 60; npk[1] = 1000;
        run_until(2, 300);
        gap(g);
        chk("empty_clear_gap", 64'(g), 5);
        chk("empty_q2", 64'(order[1]), 1);
        // Random backpressure
        start();
        quantum = {4{16'd40}};
        psz[0] = 22; npk[0] = 1000;
        psz[1] = 30; npk[1] = 1000;
        psz[2] = 9;  npk[2] = 1000;
        release_rst();
        bp_mode = 1;
        run_until(20, 3000);
        bp_mode = 0;
        chk("bp_src_vs_out", 64'(out_pkts), 64'(src_pkts));
        chk("bp_pkt_sent", 64'(pcnt[0] + pcnt[1] + pcnt[2]), 64'(out_pkts));
        // Reset in the middle of a packet
        start();
        quantum = {4{16'd58}};
        psz[0] = 58; npk[0] = 10;
        release_rst();
        for (int c = 0; c < 100 && exp_seq[0] < 5; c++) tick();
        chk("mid_beats", 64'(exp_seq[0]), 5);
        chk("mid_pre_tvalid", 64'(m_tvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(m_tvalid), 0);
        chk("mid_rst_tready", 64'(s_tready), 0);
        reset_src();
        quantum = {4{16'd58}};
        for (int q = 0; q < 2; q++) begin psz[q] = 58; npk[q] = 1000; end
        drive();
        release_rst();
        chk("mid_post_grant", 64'(grant_q), 0);
        tick();
        chk("mid_post_tvalid", 64'(m_tvalid), 1);
        run_until(2, 200);
        chk("mid_post_order0", 64'(order[0]), 0);
        chk("mid_post_order1", 64'(order[1]), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
